// File: rtl/bist_signature_checker.sv
// BIST run controller: clears the MISR, enables it for a latched pattern count, then
// captures the final signature and compares it against a latched golden value.
module bist_signature_checker #(
   parameter int unsigned N    = 8,
   parameter int unsigned CW   = 16,
   parameter int unsigned PIPE = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [CW-1:0] pattern_count,
   input  logic [N-1:0]  golden,
   input  logic [N-1:0]  misr_sig,
   output logic          misr_clear,
   output logic          misr_en,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic          fail,
   output logic [N-1:0]  sig_captured
);

   localparam int unsigned SW = (PIPE > 1) ? $clog2(PIPE) : 1;
   localparam logic [SW-1:0] SettleLoad = SW'(PIPE - 1);

   typedef enum logic [2:0] {
      StIdle, StClear, StRun, StSettle, StCompare, StDone
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  gold_q, gold_d;
   logic [N-1:0]  sig_q, sig_d;
   logic [SW-1:0] settle_q, settle_d;
   logic          clear_q, clear_d;
   logic          en_q, en_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic          fail_q, fail_d;
   logic          match;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gold_d   = gold_q;
      sig_d    = sig_q;
      settle_d = settle_q;
      match    = (sig_q == gold_q);

      unique case (state_q)
         StIdle, StDone: begin
            if (abort) begin
               state_d = StIdle;
            end else if (start) begin
               state_d = StClear;
               cnt_d   = pattern_count;
               gold_d  = golden;
            end
         end
         StClear: begin
            if (abort) begin
               state_d = StIdle;
            end else if (cnt_q != '0) begin
               state_d = StRun;
            end else begin
               state_d  = StSettle;
               settle_d = SettleLoad;
            end
         end
         StRun: begin
            if (abort) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d  = StSettle;
                  settle_d = SettleLoad;
               end
            end
         end
         StSettle: begin
            if (abort) begin
               state_d = StIdle;
            end else if (settle_q == '0) begin
               state_d = StCompare;
               sig_d   = misr_sig;
            end else begin
               settle_d = settle_q - SW'(1);
            end
         end
         StCompare: begin
            state_d = abort ? StIdle : StDone;
         end
         default: state_d = StIdle;
      endcase

      // Outputs are decoded from the next state so they are registered with it.
      clear_d = (state_d == StClear);
      en_d    = (state_d == StRun);
      busy_d  = (state_d inside {StClear, StRun, StSettle, StCompare});
      done_d  = (state_d == StDone);
      pass_d  = done_d & ((state_q == StCompare) ? match : pass_q);
      fail_d  = done_d & ((state_q == StCompare) ? !match : fail_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         gold_q   <= '0;
         sig_q    <= '0;
         settle_q <= '0;
         clear_q  <= 1'b0;
         en_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         fail_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gold_q   <= gold_d;
         sig_q    <= sig_d;
         settle_q <= settle_d;
         clear_q  <= clear_d;
         en_q     <= en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
      end
   end

   assign misr_clear   = clear_q;
   assign misr_en      = en_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign fail         = fail_q;
   assign sig_captured = sig_q;

endmodule

// File: tb/tb_bist_signature_checker.sv
// Bench for bist_signature_checker: two instances (CW=16/PIPE=1 and CW=4/PIPE=3), each fed
// by a behavioural MISR; expected signatures are folded directly from the pattern data.
module tb_bist_signature_checker;

   localparam logic [7:0] SEED = 8'hA5;
   localparam logic [7:0] POLY = 8'h1D;

   logic       clk = 1'b0;
   logic       rst;
   logic       start [2];
   logic       abort [2];
   logic [15:0] pc [2];
   logic [7:0] golden [2];
   logic [7:0] misr_q [2] = '{8'h00, 8'h00};
   int         k [2] = '{0, 0};
   logic       misr_clear [2];
   logic       misr_en [2];
   logic       busy [2];
   logic       done [2];
   logic       pass [2];
   logic       fail [2];
   logic [7:0] sig_cap [2];
   logic [7:0] data_mem [64];

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   bist_signature_checker #(.N(8), .CW(16), .PIPE(1)) u_dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
      .pattern_count(pc[0]), .golden(golden[0]), .misr_sig(misr_q[0]),
      .misr_clear(misr_clear[0]), .misr_en(misr_en[0]), .busy(busy[0]), .done(done[0]),
      .pass(pass[0]), .fail(fail[0]), .sig_captured(sig_cap[0])
   );

   bist_signature_checker #(.N(8), .CW(4), .PIPE(3)) u_dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
      .pattern_count(pc[1][3:0]), .golden(golden[1]), .misr_sig(misr_q[1]),
      .misr_clear(misr_clear[1]), .misr_en(misr_en[1]), .busy(busy[1]), .done(done[1]),
      .pass(pass[1]), .fail(fail[1]), .sig_captured(sig_cap[1])
   );

   function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] din);
      return {s[6:0], 1'b0} ^ (s[7] ? POLY : 8'h00) ^ din;
   endfunction

   // Expected signature: seed folded over the first p pattern words.
   function automatic logic [7:0] ref_sig(input int p);
      logic [7:0] s = SEED;
      for (int i = 0; i < p; i++) s = misr_step(s, data_mem[i % 64]);
      return s;
   endfunction

   function automatic int pipe_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   // Behavioural MISR: clear loads the seed, each enabled cycle absorbs the next pattern word.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (misr_clear[d]) begin
            misr_q[d] <= SEED;
            k[d]      <= 0;
         end else if (misr_en[d]) begin
            misr_q[d] <= misr_step(misr_q[d], data_mem[k[d] % 64]);
            k[d]      <= k[d] + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else passed++;
   endtask

   task automatic run_check(input int id, input int d, input int p, input logic [7:0] gmask,
                            input bit hold);
      logic [7:0] exp_sig;
      int budget, en_cnt, first_en, last_en, done_edge;
      bit clr_stray;
      string tag;
      exp_sig   = ref_sig(p);
      budget    = p + pipe_of(d) + 8;
      en_cnt    = 0;
      first_en  = -1;
      last_en   = -1;
      done_edge = -1;
      clr_stray = 1'b0;
      tag = $sformatf("run%0d_dut%0d_p%0d", id, d, p);
      @(negedge clk);
      start[d]  = 1'b1;
      pc[d]     = 16'(p);
      golden[d] = exp_sig ^ gmask;
      for (int e = 0; e <= budget; e++) begin
         @(posedge clk);
         #1;
         if (e == 0) begin
            chk({tag, "_clear_at_start"}, 64'(misr_clear[d]), 64'd1);
            chk({tag, "_busy_at_start"}, 64'(busy[d]), 64'd1);
            chk({tag, "_done_cleared"}, 64'(done[d]), 64'd0);
            if (!hold) start[d] = 1'b0;
            pc[d]     = 16'($urandom);
            golden[d] = 8'($urandom);
         end else if (misr_clear[d]) begin
            clr_stray = 1'b1;
         end
         if (misr_en[d]) begin
            en_cnt++;
            if (first_en < 0) first_en = e;
            last_en = e;
         end
         if (done[d]) begin
            done_edge = e;
            break;
         end
      end
      start[d] = 1'b0;
      chk({tag, "_done_edge"}, 64'(done_edge), 64'(p + pipe_of(d) + 2));
      chk({tag, "_en_count"}, 64'(en_cnt), 64'(p));
      chk({tag, "_en_first"}, 64'(first_en), 64'((p > 0) ? 1 : -1));
      chk({tag, "_en_last"}, 64'(last_en), 64'((p > 0) ? p : -1));
      chk({tag, "_clear_stray"}, 64'(clr_stray), 64'd0);
      chk({tag, "_pass"}, 64'(pass[d]), 64'(gmask == 8'h00));
      chk({tag, "_fail"}, 64'(fail[d]), 64'(gmask != 8'h00));
      chk({tag, "_sig"}, 64'(sig_cap[d]), 64'(exp_sig));
      chk({tag, "_busy_done"}, 64'(busy[d]), 64'd0);
      @(posedge clk);
      #1;
      chk({tag, "_done_held"}, 64'(done[d]), 64'd1);
      chk({tag, "_pass_held"}, 64'(pass[d]), 64'(gmask == 8'h00));
   endtask

   typedef struct {
      int         dut;
      int         p;
      logic [7:0] gmask;
      bit         hold;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [7:0] old_sig;
      vecs[0] = '{dut: 0, p: 4,  gmask: 8'h00, hold: 1'b0};
      vecs[1] = '{dut: 0, p: 4,  gmask: 8'h01, hold: 1'b0};
      vecs[2] = '{dut: 0, p: 0,  gmask: 8'h00, hold: 1'b0};
      vecs[3] = '{dut: 0, p: 7,  gmask: 8'h00, hold: 1'b1};
      vecs[4] = '{dut: 1, p: 15, gmask: 8'h00, hold: 1'b0};
      vecs[5] = '{dut: 1, p: 0,  gmask: 8'h80, hold: 1'b0};
      vecs[6] = '{dut: 1, p: 5,  gmask: 8'h00, hold: 1'b1};
      vecs[7] = '{dut: 0, p: 2,  gmask: 8'h00, hold: 1'b0};

      for (int i = 0; i < 64; i++) data_mem[i] = 8'($urandom);
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         start[d]  = 1'b0;
         abort[d]  = 1'b0;
         pc[d]     = '0;
         golden[d] = '0;
      end

      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset_dut%0d_clear", d), 64'(misr_clear[d]), 64'd0);
         chk($sformatf("reset_dut%0d_en", d), 64'(misr_en[d]), 64'd0);
         chk($sformatf("reset_dut%0d_busy", d), 64'(busy[d]), 64'd0);
         chk($sformatf("reset_dut%0d_done", d), 64'(done[d]), 64'd0);
         chk($sformatf("reset_dut%0d_pass", d), 64'(pass[d]), 64'd0);
         chk($sformatf("reset_dut%0d_fail", d), 64'(fail[d]), 64'd0);
         chk($sformatf("reset_dut%0d_sig", d), 64'(sig_cap[d]), 64'd0);
      end
      #20;
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 8; i++) run_check(i, vecs[i].dut, vecs[i].p, vecs[i].gmask, vecs[i].hold);

      // Abort in the third RUN cycle of a P=10 run.
      old_sig = sig_cap[0];
      @(negedge clk);
      start[0]  = 1'b1;
      pc[0]     = 16'd10;
      golden[0] = 8'($urandom);
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      abort[0] = 1'b1;
      @(posedge clk);
      #1;
      abort[0] = 1'b0;
      chk("abort_en", 64'(misr_en[0]), 64'd0);
      chk("abort_busy", 64'(busy[0]), 64'd0);
      chk("abort_done", 64'(done[0]), 64'd0);
      chk("abort_pass_fail", 64'({pass[0], fail[0]}), 64'd0);
      chk("abort_sig_kept", 64'(sig_cap[0]), 64'(old_sig));
      @(posedge clk);
      #1;
      chk("abort_stays_idle", 64'(busy[0]), 64'd0);
      run_check(20, 0, 2, 8'h00, 1'b0);

      // Abort and start together in DONE: abort wins.
      @(negedge clk);
      start[0] = 1'b1;
      abort[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      abort[0] = 1'b0;
      chk("abort_start_done", 64'(done[0]), 64'd0);
      chk("abort_start_busy", 64'(busy[0]), 64'd0);
      chk("abort_start_clear", 64'(misr_clear[0]), 64'd0);
      @(posedge clk);
      #1;
      chk("abort_start_idle", 64'(busy[0]), 64'd0);

      // Asynchronous reset in the middle of a run.
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         start[d]  = 1'b1;
         pc[d]     = 16'd9;
         golden[d] = 8'($urandom);
      end
      repeat (5) @(posedge clk);
      #2;
      chk("midrun_en_before_rst", 64'(misr_en[0]), 64'd1);
      rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("midrun_rst_dut%0d_en", d), 64'(misr_en[d]), 64'd0);
         chk($sformatf("midrun_rst_dut%0d_busy", d), 64'(busy[d]), 64'd0);
         chk($sformatf("midrun_rst_dut%0d_outs", d),
             64'({misr_clear[d], done[d], pass[d], fail[d]}), 64'd0);
         chk($sformatf("midrun_rst_dut%0d_sig", d), 64'(sig_cap[d]), 64'd0);
         start[d] = 1'b0;
      end
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         int d, p;
         logic [7:0] gm;
         d  = int'($urandom_range(0, 1));
         p  = (d == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 40));
         gm = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
         run_check(100 + i, d, p, gm, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
